led_blink_pio: RTL and testbench



---
 rtl/led_blink_pio_pkg.sv | 15 +
 rtl/led_blink_pio_if.sv | 20 ++
 rtl/led_blink_pio_timer.sv | 50 +++++
 rtl/led_blink_pio.sv | 79 +++++++
 tb/tb_led_blink_pio.sv | 217 +++++++++++++++++++++
 5 files changed

// File: rtl/led_blink_pio_pkg.sv
// Shared constants for the LED blink PIO: register map and default widths.
package led_pio_pkg;

    localparam logic [2:0] ADDR_DATA     = 3'd0;
    localparam logic [2:0] ADDR_SET      = 3'd1;
    localparam logic [2:0] ADDR_CLEAR    = 3'd2;
    localparam logic [2:0] ADDR_MODE     = 3'd3;
    localparam logic [2:0] ADDR_PRESCALE = 3'd4;
    localparam logic [2:0] ADDR_PERIOD   = 3'd5;

    localparam int DEF_WIDTH    = 8;
    localparam int DEF_PRESC_W  = 16;
    localparam int DEF_PERIOD_W = 8;

endpackage

// File: rtl/led_blink_pio_if.sv
// Avalon-MM slave bus bundle for the LED blink PIO.
interface led_blink_pio_if;

    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (
        output address, chipselect, write_n, writedata,
        input  readdata
    );

    modport slave (
        input  address, chipselect, write_n, writedata,
        output readdata
    );

endinterface

// File: rtl/led_blink_pio_timer.sv
// Blink timer: prescaler producing ticks, half-period counter toggling phase.
// A restart clears both counters and forces phase high, overriding any tick.
module led_blink_timer #(
    parameter int PRESC_W  = 16,
    parameter int PERIOD_W = 8
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [PRESC_W-1:0]  prescale,
    input  logic [PERIOD_W-1:0] period,
    input  logic                restart,
    output logic                phase
);

    logic [PRESC_W-1:0]  presc_cnt;
    logic [PERIOD_W-1:0] period_cnt;
    logic                tick;

    assign tick = (presc_cnt == prescale) && !restart;

    // Prescaler: count up to the reload value, then wrap to 0 on the tick.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            presc_cnt <= '0;
        end else if (restart || tick) begin
            presc_cnt <= '0;
        end else begin
            presc_cnt <= presc_cnt + PRESC_W'(1);
        end
    end

    // Half-period counter: flips phase every PERIOD ticks; PERIOD=0 pins phase high.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            period_cnt <= '0;
            phase      <= 1'b1;
        end else if (restart || period == '0) begin
            period_cnt <= '0;
            phase      <= 1'b1;
        end else if (tick) begin
            if (period_cnt == period - PERIOD_W'(1)) begin
                period_cnt <= '0;
                phase      <= ~phase;
            end else begin
                period_cnt <= period_cnt + PERIOD_W'(1);
            end
        end
    end

endmodule

// File: rtl/led_blink_pio.sv
// LED output port: DATA/SET/CLEAR/MODE/PRESCALE/PERIOD registers on an
// Avalon-MM slave, with per-channel blink gating driven by led_blink_timer.
module led_blink_pio
    import led_pio_pkg::*;
#(
    parameter int               WIDTH       = DEF_WIDTH,
    parameter int               PRESC_W     = DEF_PRESC_W,
    parameter int               PERIOD_W    = DEF_PERIOD_W,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic                 clk,
    input  logic                 reset_n,
    led_blink_pio_if.slave       bus,
    output logic [WIDTH-1:0]     out_port
);

    logic [WIDTH-1:0]    data_q;
    logic [WIDTH-1:0]    mode_q;
    logic [PRESC_W-1:0]  presc_q;
    logic [PERIOD_W-1:0] period_q;
    logic                wr_en;
    logic                timer_restart;
    logic                phase;
    logic [31:0]         rdata;

    assign wr_en         = bus.chipselect && !bus.write_n;
    assign timer_restart = wr_en && (bus.address == ADDR_PRESCALE ||
                                     bus.address == ADDR_PERIOD);

    // Register file writes; SET/CLEAR modify DATA atomically, 6..7 are ignored.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_q   <= RESET_VALUE;
            mode_q   <= '0;
            presc_q  <= '0;
            period_q <= '0;
        end else if (wr_en) begin
            case (bus.address)
                ADDR_DATA:     data_q   <= bus.writedata[WIDTH-1:0];
                ADDR_SET:      data_q   <= data_q | bus.writedata[WIDTH-1:0];
                ADDR_CLEAR:    data_q   <= data_q & ~bus.writedata[WIDTH-1:0];
                ADDR_MODE:     mode_q   <= bus.writedata[WIDTH-1:0];
                ADDR_PRESCALE: presc_q  <= bus.writedata[PRESC_W-1:0];
                ADDR_PERIOD:   period_q <= bus.writedata[PERIOD_W-1:0];
                default: ;
            endcase
        end
    end

    // Zero-wait read mux; write-only and reserved words read as zero.
    always_comb begin
        rdata = '0;
        case (bus.address)
            ADDR_DATA:     rdata = 32'(data_q);
            ADDR_MODE:     rdata = 32'(mode_q);
            ADDR_PRESCALE: rdata = 32'(presc_q);
            ADDR_PERIOD:   rdata = 32'(period_q);
            default:       rdata = '0;
        endcase
    end

    assign bus.readdata = rdata;

    led_blink_timer #(
        .PRESC_W  (PRESC_W),
        .PERIOD_W (PERIOD_W)
    ) u_timer (
        .clk      (clk),
        .reset_n  (reset_n),
        .prescale (presc_q),
        .period   (period_q),
        .restart  (timer_restart),
        .phase    (phase)
    );

    // Blinking channels are gated by phase; static channels pass DATA through.
    assign out_port = data_q & (~mode_q | {WIDTH{phase}});

endmodule

// File: tb/tb_led_blink_pio.sv
// Bench for led_blink_pio: an 8-bit instance checked against a time-based
// model of the blink behaviour, plus a 32-bit instance for full-width data.
module tb_led_blink_pio;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [7:0]  out8;
    logic [31:0] out32;
    int          n_tests = 0;
    int          n_fail  = 0;

    always #5 clk = ~clk;

    led_blink_pio_if bus8();
    led_blink_pio_if bus32();

    led_blink_pio #(
        .WIDTH(8), .PRESC_W(16), .PERIOD_W(8), .RESET_VALUE(8'h5A)
    ) dut8 (
        .clk(clk), .reset_n(reset_n), .bus(bus8), .out_port(out8)
    );

    led_blink_pio #(
        .WIDTH(32), .PRESC_W(16), .PERIOD_W(8), .RESET_VALUE(32'h0)
    ) dut32 (
        .clk(clk), .reset_n(reset_n), .bus(bus32), .out_port(out32)
    );

    // Reference state: registers plus cycles elapsed since the last timer restart.
    logic [7:0]  m_data, m_mode, m_period;
    logic [15:0] m_presc;
    logic [31:0] m_data32;
    int          m_t;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_data <= 8'h5A; m_mode <= '0; m_presc <= '0; m_period <= '0;
            m_t <= 0; m_data32 <= '0;
        end else begin
            m_t <= m_t + 1;
            if (bus8.chipselect && !bus8.write_n) begin
                case (bus8.address)
                    3'd0: m_data <= bus8.writedata[7:0];
                    3'd1: m_data <= m_data | bus8.writedata[7:0];
                    3'd2: m_data <= m_data & ~bus8.writedata[7:0];
                    3'd3: m_mode <= bus8.writedata[7:0];
                    3'd4: begin m_presc <= bus8.writedata[15:0]; m_t <= 0; end
                    3'd5: begin m_period <= bus8.writedata[7:0]; m_t <= 0; end
                    default: ;
                endcase
            end
            if (bus32.chipselect && !bus32.write_n) begin
                case (bus32.address)
                    3'd0: m_data32 <= bus32.writedata;
                    3'd1: m_data32 <= m_data32 | bus32.writedata;
                    3'd2: m_data32 <= m_data32 & ~bus32.writedata;
                    default: ;
                endcase
            end
        end
    end

    // Phase is high during even-numbered half-periods since the restart.
    function automatic logic [7:0] m_out();
        int   half;
        logic ph;
        if (m_period == 0) begin
            ph = 1'b1;
        end else begin
            half = (int'(m_presc) + 1) * int'(m_period);
            ph = ((m_t / half) % 2) == 0;
        end
        return m_data & (~m_mode | {8{ph}});
    endfunction

    function automatic logic [31:0] m_read(input logic [2:0] a);
        case (a)
            3'd0:    return 32'(m_data);
            3'd3:    return 32'(m_mode);
            3'd4:    return 32'(m_presc);
            3'd5:    return 32'(m_period);
            default: return 32'h0;
        endcase
    endfunction

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic bus_wr(input bit wide, input logic [2:0] a, input logic [31:0] d);
        if (wide) begin
            bus32.address = a; bus32.writedata = d; bus32.chipselect = 1'b1; bus32.write_n = 1'b0;
        end else begin
            bus8.address = a; bus8.writedata = d; bus8.chipselect = 1'b1; bus8.write_n = 1'b0;
        end
        @(posedge clk);
        @(negedge clk);
        bus8.chipselect = 1'b0;  bus8.write_n = 1'b1;
        bus32.chipselect = 1'b0; bus32.write_n = 1'b1;
    endtask

    task automatic rd_check(input string tag, input logic [2:0] a);
        bus8.address = a;
        #1;
        check_val(tag, bus8.readdata, m_read(a));
    endtask

    task automatic step_check(input string tag, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            check_val(tag, 32'(out8), 32'(m_out()));
        end
    endtask

    initial begin
        logic [2:0]  ra;
        logic [31:0] rd;
        bus8.address = '0;  bus8.chipselect = 1'b0;  bus8.write_n = 1'b1;  bus8.writedata = '0;
        bus32.address = '0; bus32.chipselect = 1'b0; bus32.write_n = 1'b1; bus32.writedata = '0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;

        check_val("rst_out", 32'(out8), 32'h5A);
        for (int a = 0; a < 8; a++) begin
            bus8.address = 3'(a);
            #1;
            check_val("rst_rd", bus8.readdata, (a == 0) ? 32'h5A : 32'h0);
        end

        bus_wr(0, 3'd0, 32'hF0);
        check_val("data_out", 32'(out8), 32'hF0);
        bus_wr(0, 3'd1, 32'h0F);
        check_val("set_out", 32'(out8), 32'hFF);
        bus_wr(0, 3'd2, 32'h81);
        check_val("clear_out", 32'(out8), 32'h7E);
        bus8.address = 3'd0; #1; check_val("data_rd", bus8.readdata, 32'h7E);
        bus8.address = 3'd1; #1; check_val("set_rd0", bus8.readdata, 32'h0);
        bus8.address = 3'd2; #1; check_val("clear_rd0", bus8.readdata, 32'h0);

        // PRESCALE=3, PERIOD=2: half-period of 8 cycles after the last write.
        bus_wr(0, 3'd0, 32'hFF);
        bus_wr(0, 3'd3, 32'h03);
        bus_wr(0, 3'd4, 32'd3);
        bus_wr(0, 3'd5, 32'd2);
        repeat (7) @(negedge clk);
        check_val("blink_pre", 32'(out8), 32'hFF);
        @(negedge clk);
        check_val("blink_low", 32'(out8), 32'hFC);
        step_check("blink_model", 24);

        bus_wr(0, 3'd5, 32'd0);
        check_val("period0_out", 32'(out8), 32'hFF);
        step_check("period0_hold", 12);
        bus_wr(0, 3'd5, 32'd1);
        repeat (3) @(negedge clk);
        check_val("period1_pre", 32'(out8), 32'hFF);
        @(negedge clk);
        check_val("period1_low", 32'(out8), 32'hFC);
        step_check("period1_model", 12);

        repeat (2) @(negedge clk);
        bus_wr(0, 3'd4, 32'd1);
        check_val("restart_phase", 32'(out8), 32'hFF);
        @(negedge clk);
        check_val("restart_pre", 32'(out8), 32'hFF);
        @(negedge clk);
        check_val("restart_low", 32'(out8), 32'hFC);
        step_check("restart_model", 10);

        #2 reset_n = 1'b0;
        #1;
        check_val("async_rst8", 32'(out8), 32'h5A);
        check_val("async_rst32", out32, 32'h0);
        @(negedge clk);
        reset_n = 1'b1;

        bus_wr(0, 3'd6, 32'hFFFF_FFFF);
        bus_wr(0, 3'd7, 32'hFFFF_FFFF);
        for (int a = 0; a < 8; a++) rd_check("reserved_rd", 3'(a));
        check_val("reserved_out", 32'(out8), 32'h5A);

        for (int it = 0; it < 400; it++) begin
            if ($urandom_range(0, 9) < 3) begin
                ra = 3'($urandom_range(0, 7));
                case (ra)
                    3'd4:    rd = $urandom_range(0, 5);
                    3'd5:    rd = $urandom_range(0, 4);
                    default: rd = $urandom;
                endcase
                bus_wr(0, ra, rd);
            end else begin
                @(negedge clk);
            end
            check_val("rand_out", 32'(out8), 32'(m_out()));
            rd_check("rand_rd", 3'($urandom_range(0, 7)));
        end

        bus_wr(1, 3'd0, 32'hDEAD_BEEF);
        bus32.address = 3'd0; #1;
        check_val("w32_rd", bus32.readdata, 32'hDEAD_BEEF);
        check_val("w32_out", out32, 32'hDEAD_BEEF);
        for (int it = 0; it < 20; it++) begin
            bus_wr(1, 3'($urandom_range(0, 2)), $urandom);
            bus32.address = 3'd0; #1;
            check_val("w32_rand_rd", bus32.readdata, m_data32);
            check_val("w32_rand_out", out32, m_data32);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
